// File: rtl/item_code_entry_if.sv
// ---------------------------------------------------------------------------
// item_code_entry_if
// Bus bundle between the keypad front end and the item-code entry block.
//
// Signals
//   ARM        session-active level (card accepted); low = abort / idle
//   KEY_VALID  single-cycle strobe marking a keypad digit
//   KEY_DIGIT  keypad digit, meaningful only while KEY_VALID = 1
//   ITEM_CODE  assembled item code (registered)
//   CODE_READY single-cycle pulse: ITEM_CODE is valid
//   CODE_ERR   single-cycle pulse: illegal digit or out-of-range code
//   TIMEOUT    single-cycle pulse: entry abandoned through inactivity
//   BUSY       high while a code entry is in progress
//
// Modports
//   master : keypad / session side, drives ARM and the key strobe
//   slave  : the entry block, drives the code and the status pulses
// ---------------------------------------------------------------------------
interface item_code_entry_if;
  logic       ARM;
  logic       KEY_VALID;
  logic [3:0] KEY_DIGIT;
  logic [4:0] ITEM_CODE;
  logic       CODE_READY;
  logic       CODE_ERR;
  logic       TIMEOUT;
  logic       BUSY;

  modport master (
    output ARM,
    output KEY_VALID,
    output KEY_DIGIT,
    input  ITEM_CODE,
    input  CODE_READY,
    input  CODE_ERR,
    input  TIMEOUT,
    input  BUSY
  );

  modport slave (
    input  ARM,
    input  KEY_VALID,
    input  KEY_DIGIT,
    output ITEM_CODE,
    output CODE_READY,
    output CODE_ERR,
    output TIMEOUT,
    output BUSY
  );
endinterface

// File: rtl/item_code_entry.sv
// ---------------------------------------------------------------------------
// item_code_entry
// Collects two decimal keypad digits (tens, units) during an armed session
// and produces a registered item code in the range 0..19. Codes above 19
// are reported as 31 together with an error pulse. Illegal digits (>9)
// abort the entry with an error pulse; inactivity aborts it with TIMEOUT.
//
// Parameters
//   TIMEOUT_CYCLES  maximum idle cycles allowed between digit entries
//
// Ports
//   CLK    system clock, rising edge
//   RESET  synchronous, active-high reset
//   bus    item_code_entry_if.slave (ARM, KEY_VALID, KEY_DIGIT in;
//          ITEM_CODE, CODE_READY, CODE_ERR, TIMEOUT, BUSY out)
// ---------------------------------------------------------------------------
module item_code_entry #(
  parameter int TIMEOUT_CYCLES = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  item_code_entry_if.slave  bus
);

  // The timer only ever needs to reach TIMEOUT_CYCLES-1; expiry is detected
  // there, so clog2(TIMEOUT_CYCLES) bits are enough.
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] MAX_DIGIT = 4'd9;
  localparam logic [6:0] MAX_CODE  = 7'd19;
  localparam logic [4:0] ERR_CODE  = 5'd31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Saturating increment: the timer sticks at all-ones instead of wrapping.
  function automatic logic [TIMER_W-1:0] satInc(input logic [TIMER_W-1:0] t);
    return (&t) ? t : t + TIMER_W'(1);
  endfunction

  // Two decimal digits to a binary value; 9*10+9 = 99 fits in 7 bits.
  function automatic logic [6:0] codeValue(input logic [3:0] tensDigit,
                                           input logic [3:0] unitsDigit);
    return (7'(tensDigit) * 7'd10) + 7'(unitsDigit);
  endfunction

  // Out-of-range codes are replaced by the reserved error code 31.
  function automatic logic [4:0] clampCode(input logic [6:0] value);
    return (value <= MAX_CODE) ? value[4:0] : ERR_CODE;
  endfunction

  state_t               state,      stateNext;
  logic [TIMER_W-1:0]   timer,      timerNext;
  logic [3:0]           tens,       tensNext;
  logic [4:0]           itemCode,   itemCodeNext;
  logic                 codeReady,  codeReadyNext;
  logic                 codeErr,    codeErrNext;
  logic                 timeoutOut, timeoutNext;
  logic [6:0]           value;
  logic                 digitLegal;
  logic                 timerExpired;

  assign value        = codeValue(tens, bus.KEY_DIGIT);
  assign digitLegal   = (bus.KEY_DIGIT <= MAX_DIGIT);
  assign timerExpired = (timer == TIMER_LAST);

  // Next-state and next-output decode. Priority inside an entry is:
  // ARM drop, then a key strobe, then timer expiry.
  always_comb begin
    stateNext     = state;
    timerNext     = timer;
    tensNext      = tens;
    itemCodeNext  = itemCode;
    codeReadyNext = 1'b0;
    codeErrNext   = 1'b0;
    timeoutNext   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.ARM) begin
          stateNext = WAIT_D1;
          timerNext = '0;
          tensNext  = '0;
        end
      end

      WAIT_D1, WAIT_D2: begin
        if (!bus.ARM) begin
          // Session aborted: leave silently, ITEM_CODE untouched.
          stateNext = IDLE;
        end else if (bus.KEY_VALID) begin
          if (!digitLegal) begin
            codeErrNext = 1'b1;
            stateNext   = IDLE;
          end else if (state == WAIT_D1) begin
            tensNext  = bus.KEY_DIGIT;
            timerNext = '0;
            stateNext = WAIT_D2;
          end else begin
            itemCodeNext  = clampCode(value);
            codeReadyNext = 1'b1;
            codeErrNext   = (value > MAX_CODE);
            stateNext     = HOLD;
          end
        end else if (timerExpired) begin
          timeoutNext = 1'b1;
          stateNext   = IDLE;
        end else begin
          timerNext = satInc(timer);
        end
      end

      HOLD: begin
        // Code is held until the session ends; keys are ignored here.
        if (!bus.ARM) begin
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything so no pulse can
  // appear on the cycle after reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      timer      <= '0;
      tens       <= '0;
      itemCode   <= '0;
      codeReady  <= 1'b0;
      codeErr    <= 1'b0;
      timeoutOut <= 1'b0;
    end else begin
      state      <= stateNext;
      timer      <= timerNext;
      tens       <= tensNext;
      itemCode   <= itemCodeNext;
      codeReady  <= codeReadyNext;
      codeErr    <= codeErrNext;
      timeoutOut <= timeoutNext;
    end
  end

  assign bus.ITEM_CODE  = itemCode;
  assign bus.CODE_READY = codeReady;
  assign bus.CODE_ERR   = codeErr;
  assign bus.TIMEOUT    = timeoutOut;
  assign bus.BUSY       = (state == WAIT_D1) || (state == WAIT_D2);

endmodule

// File: tb/tb_item_code_entry.sv
// ---------------------------------------------------------------------------
// tb_item_code_entry
// Directed bench for item_code_entry (TIMEOUT_CYCLES = 5). Each step drives
// one cycle of stimulus, queues the outputs expected after the next rising
// edge, then pops and compares them once that edge has passed.
// ---------------------------------------------------------------------------
module tb_item_code_entry;

  typedef struct packed {
    logic       rdy;
    logic       err;
    logic       to;
    logic [4:0] code;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t sb[$];

  item_code_entry_if bus();

  item_code_entry #(.TIMEOUT_CYCLES(5)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic r, input logic a, input logic kv,
                      input logic [3:0] d, input logic eRdy, input logic eErr,
                      input logic eTo, input logic [4:0] eCode,
                      input logic eBusy, input string tag);
    exp_t e;
    rst           = r;
    bus.ARM       = a;
    bus.KEY_VALID = kv;
    bus.KEY_DIGIT = d;
    sb.push_back('{rdy: eRdy, err: eErr, to: eTo, code: eCode, busy: eBusy});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (bus.CODE_READY === e.rdy) else begin
      errors++;
      $error("FAIL %s CODE_READY observed=%0b expected=%0b", tag, bus.CODE_READY, e.rdy);
    end
    checks++;
    assert (bus.CODE_ERR === e.err) else begin
      errors++;
      $error("FAIL %s CODE_ERR observed=%0b expected=%0b", tag, bus.CODE_ERR, e.err);
    end
    checks++;
    assert (bus.TIMEOUT === e.to) else begin
      errors++;
      $error("FAIL %s TIMEOUT observed=%0b expected=%0b", tag, bus.TIMEOUT, e.to);
    end
    checks++;
    assert (bus.ITEM_CODE === e.code) else begin
      errors++;
      $error("FAIL %s ITEM_CODE observed=%0d expected=%0d", tag, bus.ITEM_CODE, e.code);
    end
    checks++;
    assert (bus.BUSY === e.busy) else begin
      errors++;
      $error("FAIL %s BUSY observed=%0b expected=%0b", tag, bus.BUSY, e.busy);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.ARM       = 1'b0;
    bus.KEY_VALID = 1'b0;
    bus.KEY_DIGIT = 4'd0;

    //    rst  arm  kv  dig    rdy  err  to   code    busy
    // Reset state, and reset beating ARM/KEY_VALID
    step(1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, "reset");
    step(1'b1, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, "reset_prio");
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, "arm_wd1");

    // Keys 1 then 7, two cycles apart -> 17
    step(1'b0, 1'b1, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, "k17_d1");
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, "k17_gap");
    step(1'b0, 1'b1, 1'b1, 4'd7,  1'b1, 1'b0, 1'b0, 5'd17, 1'b0, "k17_ready");
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd17, 1'b0, "k17_pulse_end");
    step(1'b0, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 5'd17, 1'b0, "hold_ignore_key");
    step(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd17, 1'b0, "hold_to_idle");
    step(1'b0, 1'b0, 1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 5'd17, 1'b0, "idle_ignore_key");

    // Keys 4 then 2 -> 42 out of range -> 31 with READY and ERR together
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd17, 1'b1, "k42_arm");
    step(1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 5'd17, 1'b1, "k42_d1");
    step(1'b0, 1'b1, 1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 5'd31, 1'b0, "k42_range");
    step(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd31, 1'b0, "k42_idle");

    // Key 0 then five idle cycles -> TIMEOUT
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd31, 1'b1, "to_arm");
    step(1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 5'd31, 1'b1, "to_d1");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, "to_wait");
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 5'd31, 1'b0, "to_fire");
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd31, 1'b1, "to_rearm");

    // Key 0, four idle cycles, key 3 on the fifth -> key wins, code 3
    step(1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 5'd31, 1'b1, "kw_d1");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, "kw_wait");
    step(1'b0, 1'b1, 1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 5'd3,  1'b0, "kw_key_wins");
    step(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd3,  1'b0, "kw_idle");

    // Key 1 then illegal digit 12 -> CODE_ERR only, back to IDLE
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd3,  1'b1, "ill_arm");
    step(1'b0, 1'b1, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 5'd3,  1'b1, "ill_d1");
    step(1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 5'd3,  1'b0, "ill_d2_err");
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd3,  1'b1, "ill_rearm");
    step(1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 5'd3,  1'b0, "ill_d1_err");
    step(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd3,  1'b0, "ill_idle");

    // Key 1 then ARM drop coincident with key 3 -> silent abort
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd3,  1'b1, "ab_arm");
    step(1'b0, 1'b1, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 5'd3,  1'b1, "ab_d1");
    step(1'b0, 1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 5'd3,  1'b0, "ab_abort");

    // Reset in WAIT_D2, then fresh 0,5 -> 5
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd3,  1'b1, "rs_arm");
    step(1'b0, 1'b1, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 5'd3,  1'b1, "rs_d1");
    step(1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, "rs_reset");
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, "rs_release");
    step(1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, "rs_d1_0");
    step(1'b0, 1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 5'd5,  1'b0, "rs_code5");
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd5,  1'b0, "rs_hold");
    step(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd5,  1'b0, "rs_idle");

    // Range boundary: 19 accepted, 20 rejected
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd5,  1'b1, "b19_arm");
    step(1'b0, 1'b1, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 5'd5,  1'b1, "b19_d1");
    step(1'b0, 1'b1, 1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 5'd19, 1'b0, "b19_ready");
    step(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd19, 1'b0, "b19_idle");
    step(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd19, 1'b1, "b20_arm");
    step(1'b0, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 5'd19, 1'b1, "b20_d1");
    step(1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 5'd31, 1'b0, "b20_range");
    step(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd31, 1'b0, "b20_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
